// File: rtl/fix_add_arbiter_if.sv
// fix_add_arbiter_if
// Bundle of the request and result handshakes of fix_add_arbiter.
//   req_valid[NREQ]      requester i offers an operand pair
//   req_a/req_b[NREQ*N]  operands of requester i in bits [i*N +: N]
//   req_ready[NREQ]      one-hot (or zero) acceptance strobe
//   res_valid            result register holds a result
//   res_data[N]          sign-magnitude sum
//   res_id[IDW]          requester that owns res_data
//   res_ovf              magnitude carry-out flag
//   res_ready            consumer takes the result this cycle
// modport master: requesters plus consumer. modport slave: the arbiter/adder.
interface fix_add_arbiter_if #(
    parameter int N    = 16,
    parameter int NREQ = 4
);
    localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [NREQ-1:0]   req_valid;
    logic [NREQ*N-1:0] req_a;
    logic [NREQ*N-1:0] req_b;
    logic [NREQ-1:0]   req_ready;
    logic              res_valid;
    logic [N-1:0]      res_data;
    logic [IDW-1:0]    res_id;
    logic              res_ovf;
    logic              res_ready;

    modport master (
        output req_valid, req_a, req_b, res_ready,
        input  req_ready, res_valid, res_data, res_id, res_ovf
    );

    modport slave (
        input  req_valid, req_a, req_b, res_ready,
        output req_ready, res_valid, res_data, res_id, res_ovf
    );
endinterface

// File: rtl/fix_add_arbiter.sv
// fix_add_arbiter
// Round-robin arbiter in front of a single sign-magnitude fixed-point adder.
// One requester is accepted per cycle; its sum is registered into a one-deep
// result register that is handed to the consumer with a valid/ready handshake.
// Ports:
//   clk  - clock, all state on rising edge
//   rst  - synchronous active-high reset
//   bus  - fix_add_arbiter_if.slave (request and result handshakes)
module fix_add_arbiter #(
    parameter int Q    = 8,
    parameter int N    = 16,
    parameter int NREQ = 4
) (
    input  logic              clk,
    input  logic              rst,
    fix_add_arbiter_if.slave  bus
);
    localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1;
    // One extra bit so pointer + offset (up to 2*NREQ-1) never wraps.
    localparam logic [IDW:0]   NREQ_W   = (IDW+1)'(NREQ);
    localparam logic [IDW-1:0] PTR_INIT = IDW'(NREQ - 1);

    generate
        if (NREQ < 2 || NREQ > 8 || Q < 0 || Q > N - 1) begin : g_param_check
            $error("fix_add_arbiter: illegal parameter combination");
        end
    endgenerate

    typedef enum logic {
        S_EMPTY = 1'b0,
        S_FULL  = 1'b1
    } state_t;

    state_t         state_q, state_d;
    logic [IDW-1:0] ptr_q, ptr_d;
    logic [N-1:0]   res_data_q, res_data_d;
    logic [IDW-1:0] res_id_q, res_id_d;
    logic           res_ovf_q, res_ovf_d;

    logic           grant_found;
    logic [IDW-1:0] grant_idx;
    logic [IDW:0]   cand;
    logic           accept_en;
    logic           accept;

    logic [N-1:0]   op_a, op_b;
    logic           sign_a, sign_b;
    logic [N-2:0]   mag_a, mag_b;
    logic [N-1:0]   mag_sum;
    logic [N-2:0]   mag_r;
    logic           sign_r, ovf_r;

    // ------------------------------------------------------------------
    // Round-robin search: offsets 1..NREQ from the last grant, so the
    // last-granted requester is checked last.
    // ------------------------------------------------------------------
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        cand        = '0;
        for (int k = 1; k <= NREQ; k++) begin
            cand = {1'b0, ptr_q} + (IDW+1)'(k);
            if (cand >= NREQ_W) begin
                cand = cand - NREQ_W;
            end
            if (!grant_found && bus.req_valid[cand[IDW-1:0]]) begin
                grant_found = 1'b1;
                grant_idx   = cand[IDW-1:0];
            end
        end
    end

    // The single result slot can take a new sum when empty, or when the
    // consumer drains it in this same cycle.
    assign accept_en = !rst && ((state_q == S_EMPTY) || bus.res_ready);
    assign accept    = accept_en && grant_found;

    generate
        for (genvar gi = 0; gi < NREQ; gi++) begin : g_ready
            assign bus.req_ready[gi] = accept && (grant_idx == IDW'(gi));
        end
    endgenerate

    // ------------------------------------------------------------------
    // Sign-magnitude adder on the granted operand pair
    // ------------------------------------------------------------------
    assign op_a   = bus.req_a[grant_idx*N +: N];
    assign op_b   = bus.req_b[grant_idx*N +: N];
    assign sign_a = op_a[N-1];
    assign sign_b = op_b[N-1];
    assign mag_a  = op_a[N-2:0];
    assign mag_b  = op_b[N-2:0];

    always_comb begin
        mag_sum = {1'b0, mag_a} + {1'b0, mag_b};
        mag_r   = '0;
        sign_r  = 1'b0;
        ovf_r   = 1'b0;
        if (sign_a == sign_b) begin
            mag_r  = mag_sum[N-2:0];
            ovf_r  = mag_sum[N-1];
            sign_r = sign_a;
        end else if (mag_a >= mag_b) begin
            mag_r  = mag_a - mag_b;
            sign_r = sign_a;
        end else begin
            mag_r  = mag_b - mag_a;
            sign_r = sign_b;
        end
        // A zero magnitude is always reported as +0, including a wrapped
        // same-sign sum and -0 + -0.
        if (mag_r == '0) begin
            sign_r = 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Result FSM: next state and register loads
    // ------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        res_data_d = res_data_q;
        res_id_d   = res_id_q;
        res_ovf_d  = res_ovf_q;

        case (state_q)
            S_EMPTY: begin
                if (accept) begin
                    state_d = S_FULL;
                end
            end
            S_FULL: begin
                if (bus.res_ready && !accept) begin
                    state_d = S_EMPTY;
                end
            end
            default: begin
                state_d = S_EMPTY;
            end
        endcase

        if (accept) begin
            ptr_d      = grant_idx;
            res_data_d = {sign_r, mag_r};
            res_id_d   = grant_idx;
            res_ovf_d  = ovf_r;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_EMPTY;
            ptr_q      <= PTR_INIT;
            res_data_q <= '0;
            res_id_q   <= '0;
            res_ovf_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            res_data_q <= res_data_d;
            res_id_q   <= res_id_d;
            res_ovf_q  <= res_ovf_d;
        end
    end

    assign bus.res_valid = (state_q == S_FULL);
    assign bus.res_data  = res_data_q;
    assign bus.res_id    = res_id_q;
    assign bus.res_ovf   = res_ovf_q;

endmodule

// File: tb/tb_fix_add_arbiter.sv
// Testbench for fix_add_arbiter: directed vectors with hand-computed sums.
// Stimulus pushes the expected result when it expects an acceptance; a
// monitor on the falling edge pops and compares on every result transfer.
module tb_fix_add_arbiter;
    localparam int N    = 16;
    localparam int NREQ = 4;

    typedef struct packed {
        logic [15:0] data;
        logic [1:0]  id;
        logic        ovf;
    } exp_t;

    // Arithmetic vectors on requester 0: A, B, expected sum, expected ovf.
    localparam int NV = 8;
    localparam logic [15:0] VA [NV] = '{16'h7F00, 16'h0100, 16'h8080, 16'h8000,
                                        16'h8000, 16'h8300, 16'h0300, 16'hFFFF};
    localparam logic [15:0] VB [NV] = '{16'h0200, 16'h8100, 16'h0180, 16'h8000,
                                        16'h0000, 16'h8100, 16'h8500, 16'h8001};
    localparam logic [15:0] VS [NV] = '{16'h0100, 16'h0000, 16'h0100, 16'h0000,
                                        16'h0000, 16'h8400, 16'h8200, 16'h0000};
    localparam logic        VO [NV] = '{1'b1, 1'b0, 1'b0, 1'b0,
                                        1'b0, 1'b0, 1'b0, 1'b1};

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    fix_add_arbiter_if #(.N(N), .NREQ(NREQ)) bus ();

    fix_add_arbiter #(.Q(8), .N(N), .NREQ(NREQ)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int   checks   = 0;
    int   failures = 0;
    exp_t sb_q[$];
    logic [15:0] e_data [NREQ];
    logic        e_ovf  [NREQ];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", nm, act, req);
        end
    endtask

    task automatic set_ops(input int i, input logic [15:0] a, input logic [15:0] b);
        bus.req_a[i*N +: N] = a;
        bus.req_b[i*N +: N] = b;
    endtask

    // Stream operand set with hand-computed sums.
    task automatic load_stream();
        set_ops(0, 16'h0100, 16'h0080); e_data[0] = 16'h0180; e_ovf[0] = 1'b0;
        set_ops(1, 16'h8200, 16'h8100); e_data[1] = 16'h8300; e_ovf[1] = 1'b0;
        set_ops(2, 16'h0180, 16'h8080); e_data[2] = 16'h0100; e_ovf[2] = 1'b0;
        set_ops(3, 16'h7F00, 16'h0200); e_data[3] = 16'h0100; e_ovf[3] = 1'b1;
    endtask

    // One cycle: drive inputs, check req_ready, optionally expect a result,
    // then advance to just after the next rising edge.
    task automatic drive(input logic [3:0] v, input logic rr, input logic [3:0] exp_rdy,
                         input string nm, input bit do_push);
        exp_t e;
        bus.req_valid = v;
        bus.res_ready = rr;
        #1;
        chk(nm, {28'd0, bus.req_ready}, {28'd0, exp_rdy});
        $display("cycle %s: valid=%b res_ready=%b req_ready=%b", nm, v, rr, bus.req_ready);
        if (do_push) begin
            for (int i = 0; i < NREQ; i++) begin
                if (exp_rdy[i]) begin
                    e.data = e_data[i];
                    e.id   = 2'(i);
                    e.ovf  = e_ovf[i];
                    sb_q.push_back(e);
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(4'b0000, 1'b1, 4'b0000, "idle", 1'b0);
    endtask

    // Monitor: a transfer happens on the edge following a mid-cycle
    // observation of res_valid && res_ready.
    always @(negedge clk) begin
        if (bus.res_valid === 1'b1 && bus.res_ready === 1'b1) begin
            if (sb_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_result actual=data 0x%0h id %0d required=none",
                         bus.res_data, bus.res_id);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                $display("result: data=0x%04h id=%0d ovf=%0d (expected 0x%04h id=%0d ovf=%0d)",
                         bus.res_data, bus.res_id, bus.res_ovf, e.data, e.id, e.ovf);
                chk("res_data", {16'd0, bus.res_data}, {16'd0, e.data});
                chk("res_id",   {30'd0, bus.res_id},   {30'd0, e.id});
                chk("res_ovf",  {31'd0, bus.res_ovf},  {31'd0, e.ovf});
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

    initial begin
        rst           = 1'b1;
        bus.req_valid = '0;
        bus.req_a     = '0;
        bus.req_b     = '0;
        bus.res_ready = 1'b0;
        load_stream();
        @(posedge clk);
        #1;

        // Reset: no acceptance while rst is high, outputs cleared.
        drive(4'b1111, 1'b0, 4'b0000, "rst_ready", 1'b0);
        drive(4'b1111, 1'b0, 4'b0000, "rst_ready", 1'b0);
        rst = 1'b0;
        chk("rst_res_valid", {31'd0, bus.res_valid}, 32'd0);
        chk("rst_res_data",  {16'd0, bus.res_data},  32'd0);
        chk("rst_res_id",    {30'd0, bus.res_id},    32'd0);
        chk("rst_res_ovf",   {31'd0, bus.res_ovf},   32'd0);

        // Requester 2 only: 1.5 + (-0.5) = 1.0
        drive(4'b0100, 1'b1, 4'b0100, "r2_only", 1'b1);

        // Arithmetic corner vectors through requester 0, back to back.
        for (int i = 0; i < NV; i++) begin
            set_ops(0, VA[i], VB[i]);
            e_data[0] = VS[i];
            e_ovf[0]  = VO[i];
            drive(4'b0001, 1'b1, 4'b0001, "arith", 1'b1);
        end
        idle(2);

        // Fresh reset, then all requesters valid: ids 0,1,2,3,0,1.
        rst = 1'b1;
        drive(4'b1111, 1'b1, 4'b0000, "rst2_ready", 1'b0);
        rst = 1'b0;
        load_stream();
        for (int i = 0; i < 6; i++) begin
            drive(4'b1111, 1'b1, 4'(1 << (i % 4)), "stream", 1'b1);
        end
        idle(2);

        // Backpressure: last grant 1, so requester 2 wins, then stall.
        drive(4'b1111, 1'b1, 4'b0100, "bp_grant", 1'b1);
        for (int i = 0; i < 5; i++) begin
            drive(4'b1111, 1'b0, 4'b0000, "bp_stall", 1'b0);
            chk("bp_valid", {31'd0, bus.res_valid}, 32'd1);
            chk("bp_data",  {16'd0, bus.res_data},  32'h0100);
            chk("bp_id",    {30'd0, bus.res_id},    32'd2);
        end
        drive(4'b1111, 1'b1, 4'b1000, "bp_resume", 1'b1);
        idle(2);

        // Requesters 1 and 3 only alternate.
        drive(4'b1010, 1'b1, 4'b0010, "alt", 1'b1);
        drive(4'b1010, 1'b1, 4'b1000, "alt", 1'b1);
        drive(4'b1010, 1'b1, 4'b0010, "alt", 1'b1);
        drive(4'b1010, 1'b1, 4'b1000, "alt", 1'b1);
        idle(2);

        // Fill the slot, stall, then reset while FULL: result is discarded
        // and priority restarts at requester 0 (last grant was 2).
        drive(4'b0100, 1'b0, 4'b0100, "r39_fill", 1'b0);
        chk("r39_full", {31'd0, bus.res_valid}, 32'd1);
        rst = 1'b1;
        drive(4'b1111, 1'b0, 4'b0000, "r39_rst_ready", 1'b0);
        rst = 1'b0;
        chk("r39_res_valid", {31'd0, bus.res_valid}, 32'd0);
        drive(4'b1111, 1'b1, 4'b0001, "r39_grant0", 1'b1);
        idle(3);

        chk("scoreboard_empty", sb_q.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
